// File: rtl/vga_layer_compositor.sv
// Parametrised VGA raster timing plus N-layer priority compositor.
// Sync/blank/blink are delayed to line up with the source return latency.
module vga_layer_compositor #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int LAYERS = 4,
   parameter int COLOR_W = 12,
   parameter int SRC_LAT = 2,
   parameter int BLINK_FRAMES = 30,
   parameter logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW = $clog2(H_TOTAL),
   localparam int VW = $clog2(V_TOTAL)
) (
   input  logic                      clka,
   input  logic                      rst,
   input  logic [LAYERS*COLOR_W-1:0] layer_pixel,
   input  logic [LAYERS-1:0]         layer_valid,
   input  logic [LAYERS-1:0]         layer_en,
   input  logic [LAYERS-1:0]         blink_mask,
   input  logic [COLOR_W-1:0]        bg_color,
   output logic [HW-1:0]             h_cnt,
   output logic [VW-1:0]             v_cnt,
   output logic                      hsync,
   output logic                      vsync,
   output logic [COLOR_W-1:0]        rgb,
   output logic                      frame_start,
   output logic                      blink_phase
);

   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [BW-1:0] blk_q;
   logic          phase_q;
   logic          act_raw, hs_raw, vs_raw;

   // pipeline bits: {blink phase, vs, hs, active}
   logic [3:0]    pipe_q [SRC_LAT];
   logic [3:0]    tap;

   logic [COLOR_W-1:0] win_pix;
   logic [COLOR_W-1:0] rgb_q, rgb_d;
   logic               hs_q, vs_q;

   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == HW'(H_TOTAL - 1)) begin
         h_d = '0;
         v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
      end
   end

   assign act_raw = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
   assign hs_raw  = (h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_raw  = (v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC));

   // Gated by rst so the pulse is low while held in reset at (0,0).
   assign frame_start = rst && (h_q == '0) && (v_q == '0);

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         h_q     <= '0;
         v_q     <= '0;
         blk_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
         if (frame_start) begin
            if (blk_q == BW'(BLINK_FRAMES - 1)) begin
               blk_q   <= '0;
               phase_q <= ~phase_q;
            end else begin
               blk_q <= blk_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SRC_LAT; i++) pipe_q[i] <= 4'b0000;
      end else begin
         pipe_q[0] <= {phase_q, vs_raw, hs_raw, act_raw};
         for (int i = 1; i < SRC_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tap = pipe_q[SRC_LAT-1];

   // Walk from the lowest priority up so the lowest qualifying index wins.
   always_comb begin
      win_pix = bg_color;
      for (int i = LAYERS - 1; i >= 0; i--) begin
         if (layer_en[i] && layer_valid[i] &&
             (layer_pixel[i*COLOR_W +: COLOR_W] != KEY_COLOR) &&
             (!blink_mask[i] || tap[3]))
            win_pix = layer_pixel[i*COLOR_W +: COLOR_W];
      end
      rgb_d = tap[0] ? win_pix : '0;
   end

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         rgb_q <= '0;
         hs_q  <= ~SYNC_POL;
         vs_q  <= ~SYNC_POL;
      end else begin
         rgb_q <= rgb_d;
         hs_q  <= tap[1] ^ ~SYNC_POL;
         vs_q  <= tap[2] ^ ~SYNC_POL;
      end
   end

   assign h_cnt       = h_q;
   assign v_cnt       = v_q;
   assign rgb         = rgb_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign blink_phase = phase_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Scoreboard bench: a small-raster instance (A) for compositing, blink and reset,
// and a wide-line instance (B) for the 800-pixel timing with active-high sync.
module tb_vga_layer_compositor;

   logic        clka = 1'b0;
   logic        rst  = 1'b0;
   logic [47:0] layer_pixel;
   logic [3:0]  layer_valid, layer_en, blink_mask;
   logic [11:0] bg_color;

   logic [4:0]  a_h;
   logic [3:0]  a_v;
   logic        a_hs, a_vs, a_fs, a_ph;
   logic [11:0] a_rgb;

   logic [10:0] b_h;
   logic [2:0]  b_v;
   logic        b_hs, b_vs, b_fs, b_ph;
   logic [11:0] b_rgb;

   vga_layer_compositor #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(1'b0), .SRC_LAT(2), .BLINK_FRAMES(2)
   ) u_a (
      .clka(clka), .rst(rst), .layer_pixel(layer_pixel), .layer_valid(layer_valid),
      .layer_en(layer_en), .blink_mask(blink_mask), .bg_color(bg_color),
      .h_cnt(a_h), .v_cnt(a_v), .hsync(a_hs), .vsync(a_vs), .rgb(a_rgb),
      .frame_start(a_fs), .blink_phase(a_ph)
   );

   vga_layer_compositor #(
      .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b1), .SRC_LAT(1)
   ) u_b (
      .clka(clka), .rst(rst), .layer_pixel(layer_pixel), .layer_valid(layer_valid),
      .layer_en(layer_en), .blink_mask(blink_mask), .bg_color(bg_color),
      .h_cnt(b_h), .v_cnt(b_v), .hsync(b_hs), .vsync(b_vs), .rgb(b_rgb),
      .frame_start(b_fs), .blink_phase(b_ph)
   );

   always #5 clka = ~clka;

   localparam int K_RGB = 0, K_HS = 1, K_VS = 2, K_H = 3, K_V = 4, K_FS = 5, K_PH = 6;
   localparam int K_HSB = 7, K_VSB = 8, K_HB = 9, K_VB = 10, K_FSB = 11, K_RGBB = 12;

   typedef struct {
      int          due;
      int          kind;
      logic [11:0] exp;
      string       name;
   } item_t;

   item_t sb[$];
   int    tick = 0;
   int    nchk = 0;
   int    nerr = 0;

   always @(posedge clka) tick <= tick + 1;

   task automatic push(input int due, input int kind, input logic [11:0] exp, input string name);
      item_t it;
      it.due = due; it.kind = kind; it.exp = exp; it.name = name;
      sb.push_back(it);
   endtask

   function automatic logic [11:0] act_of(input int kind);
      case (kind)
         K_RGB:  return a_rgb;
         K_HS:   return {11'd0, a_hs};
         K_VS:   return {11'd0, a_vs};
         K_H:    return {7'd0, a_h};
         K_V:    return {8'd0, a_v};
         K_FS:   return {11'd0, a_fs};
         K_PH:   return {11'd0, a_ph};
         K_HSB:  return {11'd0, b_hs};
         K_VSB:  return {11'd0, b_vs};
         K_HB:   return {1'b0, b_h};
         K_VB:   return {9'd0, b_v};
         K_FSB:  return {11'd0, b_fs};
         default: return b_rgb;
      endcase
   endfunction

   // Monitor: compares every scoreboard entry due on this cycle, away from the active edge.
   always @(negedge clka) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == tick) begin
            nchk++;
            if (act_of(sb[i].kind) !== sb[i].exp) begin
               nerr++;
               $display("FAIL %s: tick=%0d actual=%h expected=%h",
                        sb[i].name, tick, act_of(sb[i].kind), sb[i].exp);
            end
            sb.delete(i);
         end else if (sb[i].due < tick) begin
            nchk++;
            nerr++;
            $display("FAIL %s: expired at tick=%0d (due %0d)", sb[i].name, tick, sb[i].due);
            sb.delete(i);
         end
      end
   end

   task automatic at_tick(input int n);
      while (tick < n) begin
         @(posedge clka);
         #1;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1;
      logic [11:0] ph_at[5], ph_after[5], rgb_at[5];
      ph_at    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      ph_after = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      rgb_at   = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF};

      layer_pixel = {12'h000, 12'h000, 12'h000, 12'hFFF};
      layer_valid = 4'b0001;
      layer_en    = 4'b0001;
      blink_mask  = 4'b0001;
      bg_color    = 12'h000;

      push(2, K_H,   12'd0, "reset_h");
      push(2, K_V,   12'd0, "reset_v");
      push(2, K_RGB, 12'h000, "reset_rgb");
      push(2, K_HS,  12'd1, "reset_hsync");
      push(2, K_VS,  12'd1, "reset_vsync");
      push(2, K_FS,  12'd0, "reset_frame_start");
      push(2, K_PH,  12'd1, "reset_blink_phase");
      push(2, K_HSB, 12'd0, "reset_hsync_pol1");

      t0 = 4;
      push(t0, K_FS, 12'd1, "release_frame_start");
      push(t0 + 1, K_FS, 12'd0, "frame_start_one_cycle");
      push(t0 + 23,  K_H, 12'd23, "h_last");
      push(t0 + 24,  K_H, 12'd0,  "h_wrap");
      push(t0 + 24,  K_V, 12'd1,  "v_step");
      push(t0 + 287, K_H, 12'd23, "frame_end_h");
      push(t0 + 287, K_V, 12'd11, "frame_end_v");
      push(t0 + 288, K_H, 12'd0,  "frame_wrap_h");
      push(t0 + 288, K_V, 12'd0,  "frame_wrap_v");
      for (int h = 14; h < 24; h++)
         push(t0 + h + 3, K_HS, (h >= 18 && h <= 20) ? 12'd0 : 12'd1, $sformatf("hsync_h%0d", h));
      for (int v = 0; v < 12; v++)
         push(t0 + 24*v + 3, K_VS, (v == 9 || v == 10) ? 12'd0 : 12'd1, $sformatf("vsync_v%0d", v));
      push(t0 + 8,   K_RGB, 12'hFFF, "rgb_active_5_0");
      push(t0 + 23,  K_RGB, 12'h000, "rgb_hblank_20_0");
      push(t0 + 224, K_RGB, 12'h000, "rgb_vblank_5_9");
      for (int k = 0; k < 5; k++) begin
         push(t0 + 288*k,     K_FS,  12'd1, $sformatf("frame_start_f%0d", k));
         push(t0 + 288*k,     K_PH,  ph_at[k], $sformatf("phase_at_f%0d", k));
         push(t0 + 288*k + 1, K_PH,  ph_after[k], $sformatf("phase_after_f%0d", k));
         push(t0 + 288*k + 3, K_RGB, rgb_at[k], $sformatf("blink_rgb_f%0d", k));
      end

      at_tick(t0);
      rst = 1'b1;

      // Frame 5: priority, enable, key and background, one change per pair of lines.
      push(t0 + 1501, K_RGB, 12'h00F, "prio_layer0");
      push(t0 + 1549, K_RGB, 12'hF00, "en0_off_layer1");
      push(t0 + 1597, K_RGB, 12'h0F0, "key_skip_layer2");
      push(t0 + 1607, K_RGB, 12'h000, "key_hblank_zero");
      push(t0 + 1621, K_RGB, 12'h555, "no_layer_bg");

      at_tick(t0 + 1464);
      layer_pixel = {12'h000, 12'h000, 12'hF00, 12'h00F};
      layer_valid = 4'b0011;
      layer_en    = 4'b1111;
      blink_mask  = 4'b0000;
      bg_color    = 12'h555;
      at_tick(t0 + 1512);
      layer_en    = 4'b1110;
      at_tick(t0 + 1560);
      layer_en    = 4'b1111;
      layer_pixel = {12'h00F, 12'h0F0, 12'hF00, 12'hF0F};
      layer_valid = 4'b0101;
      at_tick(t0 + 1608);
      layer_valid = 4'b0000;

      // Mid-frame reset at A pixel (10,3) of frame 6, held 3 cycles.
      t1 = t0 + 1813;
      push(t0 + 1809, K_H, 12'd9, "pre_reset_h");
      push(t0 + 1809, K_V, 12'd3, "pre_reset_v");
      for (int c = 1810; c < 1813; c++) begin
         push(t0 + c, K_H,   12'd0, "midreset_h");
         push(t0 + c, K_V,   12'd0, "midreset_v");
         push(t0 + c, K_RGB, 12'h000, "midreset_rgb");
         push(t0 + c, K_HS,  12'd1, "midreset_hsync");
         push(t0 + c, K_VS,  12'd1, "midreset_vsync");
         push(t0 + c, K_FS,  12'd0, "midreset_frame_start");
         push(t0 + c, K_HSB, 12'd0, "midreset_hsync_pol1");
      end
      push(t1,     K_FS,  12'd1, "rerelease_frame_start");
      push(t1,     K_FSB, 12'd1, "rerelease_frame_start_b");
      push(t1 + 1, K_H,   12'd1, "rerelease_h_step");
      push(t1 + 1, K_RGB, 12'h000, "rerelease_pipe_clear1");
      push(t1 + 2, K_RGB, 12'h000, "rerelease_pipe_clear2");
      push(t1 + 3, K_RGB, 12'h555, "rerelease_first_pixel");

      push(t1 + 1055, K_HB, 12'd1055, "b_h_last");
      push(t1 + 1056, K_HB, 12'd0,    "b_h_wrap");
      push(t1 + 1056, K_VB, 12'd1,    "b_v_step");
      for (int h = 838; h <= 970; h++)
         push(t1 + h + 2, K_HSB, (h >= 840 && h <= 967) ? 12'd1 : 12'd0, $sformatf("b_hsync_h%0d", h));
      push(t1 + 4224 + 2, K_VSB, 12'd0, "b_vsync_v4");
      push(t1 + 5280 + 2, K_VSB, 12'd1, "b_vsync_v5");
      push(t1 + 6336 + 2, K_VSB, 12'd0, "b_vsync_v6");
      push(t1 + 1002, K_RGBB, 12'h000, "b_rgb_hblank");
      push(t1 + 1063, K_RGBB, 12'h555, "b_rgb_bg");
      push(t1 + 7391, K_HB, 12'd1055, "b_frame_end_h");
      push(t1 + 7391, K_VB, 12'd6,    "b_frame_end_v");
      push(t1 + 7392, K_HB, 12'd0,    "b_frame_wrap_h");
      push(t1 + 7392, K_VB, 12'd0,    "b_frame_wrap_v");
      push(t1 + 7392, K_FSB, 12'd1,   "b_frame_wrap_fs");

      at_tick(t0 + 1810);
      rst = 1'b0;
      at_tick(t1);
      rst = 1'b1;

      at_tick(t1 + 7400);
      @(negedge clka);
      while (sb.size() > 0) begin
         nchk++;
         nerr++;
         $display("FAIL %s: never compared (due %0d)", sb[0].name, sb[0].due);
         sb.delete(0);
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
